// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch-stage PC with stall, execute-stage redirect and halt FSM
// Optional direct-mapped BTB enabled by defining PC_FETCH_BTB_EN.
module pc_fetch_unit #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_BYTES = 2,
  parameter int RESET_PC    = 0,
  parameter int BTB_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              hlt_dec,
  input  logic              hlt_commit,
  input  logic              br_valid,
  input  logic [1:0]        br_kind,
  input  logic              cond_true,
  input  logic [ADDR_W-1:0] br_imm,
  input  logic [ADDR_W-1:0] br_reg,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              br_pred_taken,
  input  logic [ADDR_W-1:0] br_pred_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              redirect,
  output logic              halted
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_BYTES);

  if ((BTB_DEPTH < 1) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("BTB_DEPTH must be a power of two");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;

  logic              taken, mispredict, mispredict_eff;
  logic [ADDR_W-1:0] target, fallthrough;

  always_comb begin
    taken          = br_valid & (br_kind != 2'b00) & cond_true;
    target         = br_kind[1] ? br_reg : (br_pc + INC + br_imm * INC);
    mispredict     = br_valid & ((taken != br_pred_taken) | (taken & (br_pred_target != target)));
    // A halted core must not be restarted by a stray wrong-path branch.
    mispredict_eff = mispredict & (state_q != HALTED);
    fallthrough    = taken ? target : (br_pc + INC);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = mispredict_eff;
    case (state_q)
      RUN: begin
        if (mispredict_eff) begin
          pc_d = fallthrough;
        end else if (hlt_dec & ~stall) begin
          state_d = HALT_PEND;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pred_taken) begin
          pc_d = pred_target;
        end else begin
          pc_d = pc_q + INC;
        end
      end
      HALT_PEND: begin
        if (mispredict_eff) begin
          pc_d    = fallthrough;
          state_d = RUN;
        end else if (hlt_commit) begin
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign halted   = (state_q == HALTED);

`ifdef PC_FETCH_BTB_EN
  localparam int OFF_W = $clog2(INSTR_BYTES);
  localparam int IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  logic              btb_v_q   [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_tgt_q [BTB_DEPTH];
  logic [1:0]        btb_ctr_q [BTB_DEPTH];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_en;

  always_comb begin
    l_idx       = pc_q[OFF_W +: IDX_W];
    l_tag       = pc_q[ADDR_W-1 -: TAG_W];
    l_hit       = btb_v_q[l_idx] & (btb_tag_q[l_idx] == l_tag);
    pred_taken  = l_hit & btb_ctr_q[l_idx][1];
    pred_target = l_hit ? btb_tgt_q[l_idx] : '0;
    u_idx       = br_pc[OFF_W +: IDX_W];
    u_tag       = br_pc[ADDR_W-1 -: TAG_W];
    u_hit       = btb_v_q[u_idx] & (btb_tag_q[u_idx] == u_tag);
    u_en        = br_valid & (br_kind != 2'b00);
  end

  // Lookup reads the registered arrays, so a same-index update is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_v_q[i] <= 1'b0;
    end else if (u_en) begin
      if (u_hit) begin
        if (taken) begin
          btb_tgt_q[u_idx] <= target;
          if (btb_ctr_q[u_idx] != 2'b11) btb_ctr_q[u_idx] <= btb_ctr_q[u_idx] + 2'b01;
        end else if (btb_ctr_q[u_idx] != 2'b00) begin
          btb_ctr_q[u_idx] <= btb_ctr_q[u_idx] - 2'b01;
        end
      end else if (taken) begin
        btb_v_q[u_idx]   <= 1'b1;
        btb_tag_q[u_idx] <= u_tag;
        btb_tgt_q[u_idx] <= target;
        btb_ctr_q[u_idx] <= 2'b10;
      end
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

endmodule
